// File: rtl/sigdelay_ctrl.sv
// Sequencing controller for the signal-delay datapath: turns sample ticks into
// counter/RAM strobes, primes the delay line with `offset` samples before reading.
module sigdelay_ctrl #(
  parameter int A_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_load,
  input  logic               sample_tick,
  input  logic [A_WIDTH-1:0] offset_req,
  output logic               en,
  output logic               wr_en,
  output logic               rd_en,
  output logic [A_WIDTH-1:0] offset,
  output logic               dout_valid,
  output logic               primed,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [A_WIDTH-1:0] CNT_ZERO = {A_WIDTH{1'b0}};
  localparam logic [A_WIDTH-1:0] CNT_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_s;
  logic [A_WIDTH-1:0] fill_cnt_r;
  logic [A_WIDTH-1:0] fill_cnt_s;
  logic [A_WIDTH-1:0] fill_inc_s;
  logic [A_WIDTH-1:0] offset_s;
  logic               en_s;
  logic               wr_en_s;
  logic               rd_en_s;

  assign fill_inc_s = fill_cnt_r + CNT_ONE;

  // Next-state and strobe decode; priority is stop > cfg_load > sample_tick.
  always_comb begin
    state_s    = state_r;
    fill_cnt_s = fill_cnt_r;
    offset_s   = offset;
    en_s       = 1'b0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (start) begin
          offset_s   = offset_req;
          fill_cnt_s = CNT_ZERO;
          state_s    = (offset_req != CNT_ZERO) ? ST_PRIME : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRIME, ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (cfg_load) begin
          offset_s   = offset_req;
          fill_cnt_s = CNT_ZERO;
          state_s    = (offset_req != CNT_ZERO) ? ST_PRIME : ST_RUN;
        end else if (sample_tick) begin
          en_s    = 1'b1;
          wr_en_s = 1'b1;
          if (state_r == ST_RUN) begin
            rd_en_s = 1'b1;
          end else begin
            // Write-only while filling; the tick that completes the fill moves to RUN.
            fill_cnt_s = fill_inc_s;
            state_s    = (fill_inc_s == offset) ? ST_RUN : ST_PRIME;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        fill_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; dout_valid trails rd_en by the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      fill_cnt_r <= CNT_ZERO;
      offset     <= CNT_ZERO;
      en         <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      dout_valid <= 1'b0;
      primed     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      fill_cnt_r <= fill_cnt_s;
      offset     <= offset_s;
      en         <= en_s;
      wr_en      <= wr_en_s;
      rd_en      <= rd_en_s;
      dout_valid <= rd_en;
      primed     <= (state_s == ST_RUN);
      busy       <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sigdelay_ctrl.sv
// Directed bench for sigdelay_ctrl: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and back-to-back ticks.
module tb_sigdelay_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_load = 1'b0;
  logic          sample_tick = 1'b0;
  logic [AW-1:0] offset_req = '0;
  logic          en, wr_en, rd_en, dout_valid, primed, busy;
  logic [AW-1:0] offset;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]    ctl;    // start, stop, cfg_load, sample_tick
    logic [AW-1:0] req;
    logic [5:0]    flags;  // en, wr_en, rd_en, dout_valid, primed, busy
    logic [AW-1:0] off;
  } vec_t;

  vec_t vecs[$];

  sigdelay_ctrl #(.A_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_load(cfg_load),
    .sample_tick(sample_tick), .offset_req(offset_req), .en(en), .wr_en(wr_en),
    .rd_en(rd_en), .offset(offset), .dout_valid(dout_valid), .primed(primed),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] ctl, input int req, input logic [5:0] flags, input int off);
    vec_t v;
    v.ctl   = ctl;
    v.req   = AW'(req);
    v.flags = flags;
    v.off   = AW'(off);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp_flags, input logic [AW-1:0] exp_off);
    logic [5:0] act;
    act = {en, wr_en, rd_en, dout_valid, primed, busy};
    n_cmp++;
    if (act !== exp_flags || offset !== exp_off) begin
      n_bad++;
      $display("FAIL %s: got flags(en,wr,rd,dv,pr,busy)=%b offset=%0d, want flags=%b offset=%0d",
               name, act, offset, exp_flags, exp_off);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int n_wr, n_rd, n_dv;

    // Priming offset 3, reads, reload to 5, collisions, zero offset, stop with pending read.
    add(4'b1000, 3, 6'b000001, 3);
    add(4'b0001, 0, 6'b110001, 3);
    add(4'b0000, 0, 6'b000001, 3);
    add(4'b0001, 0, 6'b110001, 3);
    add(4'b0001, 0, 6'b110011, 3);
    add(4'b0001, 0, 6'b111011, 3);
    add(4'b0000, 0, 6'b000111, 3);
    add(4'b0001, 0, 6'b111011, 3);
    add(4'b0000, 0, 6'b000111, 3);
    add(4'b0010, 5, 6'b000001, 5);
    for (int i = 0; i < 4; i++) add(4'b0001, 0, 6'b110001, 5);
    add(4'b0001, 0, 6'b110011, 5);
    add(4'b0001, 0, 6'b111011, 5);
    add(4'b0001, 0, 6'b111111, 5);
    add(4'b0000, 0, 6'b000111, 5);
    add(4'b0101, 0, 6'b000000, 5);
    add(4'b0001, 0, 6'b000000, 5);
    add(4'b0010, 7, 6'b000000, 5);
    add(4'b1000, 0, 6'b000011, 0);
    add(4'b0001, 0, 6'b111011, 0);
    add(4'b0100, 0, 6'b000100, 0);
    add(4'b1000, 2, 6'b000001, 2);
    add(4'b0001, 0, 6'b110001, 2);
    add(4'b0011, 4, 6'b000001, 4);
    for (int i = 0; i < 3; i++) add(4'b0001, 0, 6'b110001, 4);
    add(4'b0001, 0, 6'b110011, 4);
    add(4'b1000, 1, 6'b000011, 4);
    add(4'b0010, 0, 6'b000011, 0);
    add(4'b0001, 0, 6'b111011, 0);
    add(4'b0100, 0, 6'b000100, 0);

    #12;
    check("reset", 6'b000000, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {start, stop, cfg_load, sample_tick} = vecs[i].ctl;
      offset_req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].off);
      {start, stop, cfg_load, sample_tick} = 4'b0000;
      offset_req = '0;
    end

    // Asynchronous reset between edges while RUN is strobing.
    @(negedge clk); start = 1'b1; offset_req = 9'd1;
    @(negedge clk); start = 1'b0; sample_tick = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("run_before_rst", 6'b111011, 9'd1);
    rst = 1'b1;
    #1;
    check("async_rst", 6'b000000, '0);
    @(negedge clk); rst = 1'b0; sample_tick = 1'b0;
    @(negedge clk); start = 1'b1; offset_req = 9'd1;
    @(posedge clk); #1;
    check("restart", 6'b000001, 9'd1);
    @(negedge clk); start = 1'b0; sample_tick = 1'b1;
    @(posedge clk); #1;
    check("reprime_tick", 6'b110011, 9'd1);
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Eight back-to-back ticks with offset 2.
    @(negedge clk); start = 1'b1; offset_req = 9'd2;
    @(negedge clk); start = 1'b0; sample_tick = 1'b1;
    n_wr = 0; n_rd = 0; n_dv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_wr += int'(wr_en);
      n_rd += int'(rd_en);
      n_dv += int'(dout_valid);
      check_bit($sformatf("burst_rd%0d", i), rd_en, (i >= 2));
      check_bit($sformatf("burst_dv%0d", i), dout_valid, (i >= 3));
    end
    @(negedge clk); sample_tick = 1'b0;
    @(posedge clk); #1;
    n_dv += int'(dout_valid);
    check_bit("burst_tail_rd", rd_en, 1'b0);
    check_int("burst_wr_count", n_wr, 8);
    check_int("burst_rd_count", n_rd, 6);
    check_int("burst_dv_count", n_dv, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sigdelay_ctrl.md
# sigdelay_ctrl

Sequencing controller for the signal-delay datapath (address counter + dual-port RAM delay line). It turns a per-sample strobe into single-cycle `en` / `wr_en` / `rd_en` pulses. It primes the delay line with `offset` samples before enabling reads, and applies offset changes safely by re-priming. The output-valid strobe is aligned to the RAM's one-cycle read latency. It sits between the sample-rate tick generator / top-level controls and the delay datapath.

## Interface

Parameters:
- `A_WIDTH`, default 9: address width of the delay line; width of `offset` and the fill counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin delaying; honoured only in IDLE.
- `stop`  in  1  one-cycle request to halt; honoured in any state.
- `cfg_load`  in  1  one-cycle request to apply `offset_req`; honoured in PRIME and RUN.
- `sample_tick`  in  1  one-cycle strobe, one per audio sample.
- `offset_req`  in  A_WIDTH  requested delay in samples.
- `en`  out  1  address-counter advance, one-cycle pulse.
- `wr_en`  out  1  RAM write enable, one-cycle pulse.
- `rd_en`  out  1  RAM read enable, one-cycle pulse.
- `offset`  out  A_WIDTH  applied delay to the counter; stable between loads.
- `dout_valid`  out  1  RAM `dout` holds a valid delayed sample this cycle.
- `primed`  out  1  high while in RUN.
- `busy`  out  1  high while in PRIME or RUN.

## Operation

- All outputs are registered.
  - Reset value of every output is 0, including `offset`.
  - Reset puts the FSM in IDLE and clears `fill_cnt`.
- States: IDLE, PRIME, RUN.
- IDLE:
  - `sample_tick` and `cfg_load` are ignored.
  - `start` latches `offset_req` into `offset` and clears `fill_cnt`.
  - After `start`: go to PRIME if `offset_req` != 0, otherwise go directly to RUN.
- PRIME:
  - On each `sample_tick`, pulse `en` and `wr_en` (no `rd_en`), and set `fill_cnt <= fill_cnt + 1`.
  - If `fill_cnt + 1 == offset`, go to RUN.
  - `fill_cnt` never exceeds `offset`, so it never wraps.
- RUN:
  - On each `sample_tick`, pulse `en`, `wr_en` and `rd_en` together.
  - `dout_valid` pulses one cycle after `rd_en`.
- `cfg_load` in PRIME or RUN:
  - Latch `offset_req` and clear `fill_cnt`.
  - Next state is PRIME, or RUN if the new offset is 0.
  - No `rd_en` is issued until re-priming completes.
- `stop` in any state: go to IDLE. `offset` keeps its last value.
- Priority when events coincide in one cycle: `stop` > `cfg_load` > `sample_tick`.
  - A tick coinciding with a winning `stop` or `cfg_load` is dropped: no pulses, and it is not counted.
- `start` outside IDLE is ignored.
- A `sample_tick` that is held high for consecutive cycles is treated as one tick per cycle; no edge detection.

## Timing

- `sample_tick` sampled at edge N → `en` / `wr_en` (/ `rd_en`) high for exactly the cycle after edge N.
- `dout_valid` follows at N+1, i.e. one cycle after `rd_en`.
- `start` at edge N → state and `offset` updated after edge N; the first tick is serviced from the edge after that.
- Last PRIME tick at edge N → `primed` high after edge N.
  - The tick at edge N is write-only.
  - The next tick is the first read.
- `stop` at edge N:
  - `busy`, `primed`, `en`, `wr_en` and `rd_en` are 0 after edge N.
  - A `dout_valid` already scheduled from a `rd_en` issued at edge N−1 still fires after edge N.
- `rst` asserted mid-operation: all outputs drop to 0 immediately (asynchronously), with no clock edge needed.
- Steady-state throughput: one sample per `sample_tick`. Ticks may arrive on every cycle.

## Test plan

- Reset, then `start` with `offset_req`=3, then 5 ticks:
  - Ticks 1–3: `wr_en` only, `rd_en`=0.
  - `primed` rises after tick 3.
  - Ticks 4–5: `en`, `wr_en` and `rd_en` together.
  - `dout_valid` one cycle after each `rd_en`.
- `start` with `offset_req`=0 → `primed`=1 immediately. The first tick gives `rd_en`=1 with `dout_valid` on the next cycle.
- In RUN with `offset`=3, `cfg_load` with `offset_req`=5:
  - `offset`=5, `primed`=0.
  - The next 5 ticks are write-only, then reads resume.
- Same-cycle collisions:
  - `stop`+`sample_tick` → no pulses, state IDLE.
  - `cfg_load`+`sample_tick` in PRIME → `fill_cnt`=0, no pulse.
- Async `rst` pulse between clock edges during RUN → all outputs 0 before the next edge. A subsequent `start` primes afresh.
- Ticks on 8 consecutive cycles with `offset`=2 → 8 `wr_en` pulses, 6 `rd_en` pulses, 6 `dout_valid` pulses, no gaps.
